cpu_instruction_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_instruction_fetch_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/cpu_instruction_fetch.sv | 150 +++++++++++++++
 tb/tb_cpu_instruction_fetch.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the BIT-MIPS fetch stage.
//   fetch_state_e    : fetch FSM state encoding (idle / request kept / request discarded)
//   RESET_PC_DEFAULT : program counter value after reset
//   WORD_W           : machine word width
//   fetch_entry_t    : one buffered instruction {address, instruction}
package cpu_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDiscard
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] address;
      logic [WORD_W-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/cpu_instruction_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_req / imem_addr          : read request and word address (fetch -> memory)
//   imem_ready / imem_rdata       : read completion and data (memory -> fetch)
//   output_valid / _address / _instruction : head instruction (fetch -> decode)
//   output_full                   : decode back-pressure (decode -> fetch)
// master = fetch stage, slave = memory/decode side.
interface cpu_instruction_fetch_if;
   import cpu_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ready;
   logic [WORD_W-1:0] imem_rdata;
   logic [WORD_W-1:0] output_address;
   logic [WORD_W-1:0] output_instruction;
   logic              output_valid;
   logic              output_full;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata,
      output output_address,
      output output_instruction,
      output output_valid,
      input  output_full
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata,
      input  output_address,
      input  output_instruction,
      input  output_valid,
      output output_full
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer for the fetch stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : write push_data at the tail
//   pop          : drop the head entry
//   flush        : empty the buffer; overrides push and pop
//   push_data    : entry to write
//   head_data    : entry at the read pointer
//   count        : number of valid entries, 0..Depth
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 64,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [Width-1:0] push_data,
   output logic [Width-1:0] head_data,
   output logic [CntW-1:0]  count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         // Cleared so the head fields read as zero out of reset.
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/cpu_instruction_fetch.sv
// Instruction fetch stage of the BIT-MIPS pipeline.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   redirect_valid   : load redirect_target as the new PC this cycle (flushes the buffer)
//   redirect_target  : new PC; low two bits are forced to zero
//   bus (master)     : instruction memory request/response and decode-side handshake
// Holds the PC, issues one word read at a time, buffers returned words with their
// addresses in fetch_fifo and offers the head to decode. All outputs are registered.
module cpu_instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned       FIFO_DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    redirect_valid,
   input  logic [WORD_W-1:0]       redirect_target,
   cpu_instruction_fetch_if.master bus
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] pending_pc_q, pending_pc_d;
   logic [WORD_W-1:0] imem_addr_q, imem_addr_d;
   logic              imem_req_q, imem_req_d;

   logic [WORD_W-1:0] target;
   logic [WORD_W-1:0] pc_plus4;
   logic [CntW-1:0]   count;
   logic [CntW-1:0]   count_after_push;
   logic              push;
   logic              pop;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   assign target   = redirect_target & ~WORD_W'(3);
   assign pc_plus4 = pc_q + WORD_W'(4);

   // Decode takes the head whenever it is offered and not back-pressured,
   // including on a redirect edge.
   assign pop = (count != '0) && !bus.output_full;

   // Occupancy after an edge that both pushes and (maybe) pops.
   assign count_after_push = count + CntW'(1) - CntW'(pop);

   assign push_entry = '{address: pc_q, instruction: bus.imem_rdata};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      imem_req_d   = imem_req_q;
      imem_addr_d  = imem_addr_q;
      push         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (redirect_valid) begin
               // Buffer is flushed this edge, so a slot is guaranteed free.
               pc_d        = target;
               state_d     = StReq;
               imem_req_d  = 1'b1;
               imem_addr_d = target;
            end else if (count < FullCount) begin
               state_d     = StReq;
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
            end
         end

         StReq: begin
            if (redirect_valid) begin
               if (bus.imem_ready) begin
                  // Returned word belongs to the old path; reissue at the target.
                  pc_d        = target;
                  imem_addr_d = target;
               end else begin
                  // Request must stay stable until the memory completes it.
                  pending_pc_d = target;
                  state_d      = StDiscard;
               end
            end else if (bus.imem_ready) begin
               push = 1'b1;
               pc_d = pc_plus4;
               if (count_after_push < FullCount) begin
                  imem_addr_d = pc_plus4;
               end else begin
                  state_d    = StIdle;
                  imem_req_d = 1'b0;
               end
            end
         end

         StDiscard: begin
            if (redirect_valid) begin
               pending_pc_d = target;
            end else if (bus.imem_ready) begin
               pc_d        = pending_pc_q;
               imem_addr_d = pending_pc_q;
               state_d     = StReq;
            end
         end

         default: begin
            state_d    = StIdle;
            imem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         pending_pc_q <= '0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
      end
   end

   fetch_fifo #(
      .Depth (FIFO_DEPTH),
      .Width ($bits(fetch_entry_t))
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data (push_entry),
      .head_data (head_entry),
      .count     (count)
   );

   assign bus.imem_req           = imem_req_q;
   assign bus.imem_addr          = imem_addr_q;
   assign bus.output_valid       = (count != '0);
   assign bus.output_address     = head_entry.address;
   assign bus.output_instruction = head_entry.instruction;

endmodule

// File: tb/tb_cpu_instruction_fetch.sv
// Directed bench for cpu_instruction_fetch: expected transfers are queued as each
// step is set up and checked against decode-side transfers as they happen.
module tb_cpu_instruction_fetch;
   import cpu_pkg::*;

   logic              clock;
   logic              reset;
   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_target;

   cpu_instruction_fetch_if bus ();

   logic [WORD_W-1:0] exp_q [$];
   int                checks;
   int                errors;

   cpu_instruction_fetch #(
      .RESET_PC   (32'hBFC0_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .bus             (bus)
   );

   // Memory model: word content is a fixed function of its address.
   function automatic logic [WORD_W-1:0] instr_of(input logic [WORD_W-1:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   assign bus.imem_rdata = instr_of(bus.imem_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_values(input string pfx);
      check1({pfx, "_imem_req"}, bus.imem_req, 1'b0);
      check32({pfx, "_imem_addr"}, bus.imem_addr, 32'h0);
      check1({pfx, "_output_valid"}, bus.output_valid, 1'b0);
      check32({pfx, "_output_address"}, bus.output_address, 32'h0);
      check32({pfx, "_output_instruction"}, bus.output_instruction, 32'h0);
   endtask

   // Applies one reset edge, checks reset outputs and that every queued transfer was seen.
   task automatic do_reset(input string pfx);
      reset          = 1'b1;
      bus.imem_ready = 1'b0;
      bus.output_full = 1'b0;
      redirect_valid = 1'b0;
      tick();
      check_reset_values(pfx);
      check32({pfx, "_pending_transfers"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Scoreboard: every transfer to decode must match the oldest queued address.
   always @(negedge clock) begin
      if (bus.output_valid === 1'b1 && bus.output_full === 1'b0) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL xfer_unexpected: observed address %h expected no transfer",
                   bus.output_address);
         end
         if (exp_q.size() != 0) begin
            logic [WORD_W-1:0] ea;
            ea = exp_q.pop_front();
            check32("xfer_address", bus.output_address, ea);
            check32("xfer_instruction", bus.output_instruction, instr_of(ea));
         end
      end
   end

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      bus.imem_ready  = 1'b0;
      bus.output_full = 1'b0;

      tick();
      do_reset("reset");

      // Zero-wait streaming: one fetch and one transfer per cycle.
      for (int i = 0; i < 5; i++) exp_q.push_back(32'hBFC0_0000 + 32'(4 * i));
      bus.imem_ready = 1'b1;
      reset          = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check1("stream_req", bus.imem_req, 1'b1);
         check32("stream_addr", bus.imem_addr, 32'hBFC0_0000 + 32'(4 * (k - 1)));
         check1("stream_valid", bus.output_valid, (k >= 2));
      end
      do_reset("stream_end");

      // Back-pressure: two pushes fill the buffer and fetching stops.
      bus.imem_ready  = 1'b1;
      bus.output_full = 1'b1;
      reset           = 1'b0;
      tick();
      tick();
      tick();
      check1("bp_req_stopped", bus.imem_req, 1'b0);
      check1("bp_valid", bus.output_valid, 1'b1);
      check32("bp_head_addr", bus.output_address, 32'hBFC0_0000);
      check32("bp_head_instr", bus.output_instruction, instr_of(32'hBFC0_0000));
      tick();
      tick();
      check1("bp_req_held_low", bus.imem_req, 1'b0);
      exp_q.push_back(32'hBFC0_0000);
      exp_q.push_back(32'hBFC0_0004);
      exp_q.push_back(32'hBFC0_0008);
      bus.output_full = 1'b0;
      tick();
      check1("bp_drain_req", bus.imem_req, 1'b0);
      tick();
      check1("bp_resume_req", bus.imem_req, 1'b1);
      check32("bp_resume_addr", bus.imem_addr, 32'hBFC0_0008);
      tick();
      do_reset("bp_end");

      // Redirect while a slow read is outstanding: stale word dropped.
      bus.imem_ready = 1'b0;
      reset          = 1'b0;
      tick();
      check32("slow_first_addr", bus.imem_addr, 32'hBFC0_0000);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0040_0000;
      tick();
      check1("slow_req_held", bus.imem_req, 1'b1);
      check32("slow_addr_held1", bus.imem_addr, 32'hBFC0_0000);
      redirect_valid = 1'b0;
      tick();
      check32("slow_addr_held2", bus.imem_addr, 32'hBFC0_0000);
      bus.imem_ready = 1'b1;
      tick();
      check32("slow_new_addr", bus.imem_addr, 32'h0040_0000);
      check1("slow_req_new", bus.imem_req, 1'b1);
      check1("slow_stale_dropped", bus.output_valid, 1'b0);
      exp_q.push_back(32'h0040_0000);
      tick();
      check32("slow_next_addr", bus.imem_addr, 32'h0040_0004);
      do_reset("slow_end");

      // Redirect with a full buffer and an unaligned target.
      bus.imem_ready  = 1'b1;
      bus.output_full = 1'b1;
      reset           = 1'b0;
      tick();
      tick();
      tick();
      check1("flush_pre_valid", bus.output_valid, 1'b1);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0040_0003;
      tick();
      check1("flush_valid", bus.output_valid, 1'b0);
      check1("flush_req", bus.imem_req, 1'b1);
      check32("flush_addr", bus.imem_addr, 32'h0040_0000);
      redirect_valid  = 1'b0;
      bus.output_full = 1'b0;
      exp_q.push_back(32'h0040_0000);
      tick();
      check1("flush_refill_valid", bus.output_valid, 1'b1);
      do_reset("flush_end");

      // PC wrap from the top of the address space.
      bus.imem_ready  = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      reset           = 1'b0;
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      tick();
      check32("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      tick();
      check32("wrap_addr1", bus.imem_addr, 32'h0000_0000);
      tick();
      check32("wrap_addr2", bus.imem_addr, 32'h0000_0004);
      do_reset("wrap_end");

      // Reset in the middle of a request, with imem_ready high during reset.
      bus.imem_ready = 1'b0;
      reset          = 1'b0;
      tick();
      check1("midrst_req_before", bus.imem_req, 1'b1);
      reset          = 1'b1;
      bus.imem_ready = 1'b1;
      tick();
      check_reset_values("midrst");
      reset = 1'b0;
      tick();
      check1("midrst_restart_req", bus.imem_req, 1'b1);
      check32("midrst_restart_addr", bus.imem_addr, 32'hBFC0_0000);
      check1("midrst_restart_valid", bus.output_valid, 1'b0);
      reset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
